// File: rtl/regdbg_pkg.sv
// Shared types and default sizing for the register-file debug port.
package regdbg_pkg;

  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned ADDR_W_DEF   = $clog2(NUM_REGS_DEF);
  localparam int unsigned DATA_W_DEF   = 32;

  typedef logic [ADDR_W_DEF-1:0] idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StDumpRd,
    StDumpOut,
    StLoad,
    StDone
  } state_t;

endpackage

// File: rtl/regfile_debug_port.sv
// Debug initiator that walks every register of the RV32I file, either streaming
// the contents out (dump) or writing an incoming word stream into it (load).
module regfile_debug_port
  import regdbg_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_dump,
  input  logic              start_load,
  output logic              busy,
  output logic              done,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] rf_rs_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data
);

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] dump_index_q;
  logic [DATA_W-1:0] dump_data_q;
  logic              idx_last;

  assign idx_last = (idx_q == ADDR_W'(NUM_REGS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      dump_index_q <= '0;
      dump_data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Dump has priority when both requests arrive together.
          if (start_dump) begin
            state_q <= StDumpRd;
            idx_q   <= '0;
          end else if (start_load) begin
            state_q <= StLoad;
            idx_q   <= '0;
          end
        end
        StDumpRd: begin
          dump_data_q  <= rf_read_data;
          dump_index_q <= idx_q;
          state_q      <= StDumpOut;
        end
        StDumpOut: begin
          if (dump_ready) begin
            if (idx_last) begin
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + ADDR_W'(1);
              state_q <= StDumpRd;
            end
          end
        end
        StLoad: begin
          if (load_valid) begin
            if (idx_last) begin
              state_q <= StDone;
            end else begin
              idx_q <= idx_q + ADDR_W'(1);
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy          = (state_q == StDumpRd) || (state_q == StDumpOut) || (state_q == StLoad);
    done          = (state_q == StDone);
    cpu_stall     = busy;
    dump_valid    = (state_q == StDumpOut);
    load_ready    = (state_q == StLoad);
    rf_rs_addr    = idx_q;
    rf_rd_addr    = idx_q;
    rf_write_data = load_data;
    // x0 is hardwired: its load word is consumed but never written.
    rf_we         = (state_q == StLoad) && load_valid && (idx_q != '0);
    dump_index    = dump_index_q;
    dump_data     = dump_data_q;
  end

endmodule

// File: tb/tb_regfile_debug_port.sv
// Directed bench for regfile_debug_port with a behavioural register file.
module tb_regfile_debug_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_dump, start_load;
  logic        busy, done, cpu_stall;
  logic [4:0]  rf_rs_addr, rf_rd_addr, dump_index;
  logic [31:0] rf_read_data, rf_write_data, dump_data, load_data;
  logic        rf_we, dump_valid, dump_ready, load_valid, load_ready;
  logic        preload;

  logic [31:0] rf [0:31];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'(i * 3);
    end else if (rf_we) begin
      rf[rf_rd_addr] <= rf_write_data;
    end
  end

  assign rf_read_data = rf[rf_rs_addr];

  regfile_debug_port dut (
    .clk           (clk),
    .reset         (reset),
    .start_dump    (start_dump),
    .start_load    (start_load),
    .busy          (busy),
    .done          (done),
    .cpu_stall     (cpu_stall),
    .rf_rs_addr    (rf_rs_addr),
    .rf_read_data  (rf_read_data),
    .rf_we         (rf_we),
    .rf_rd_addr    (rf_rd_addr),
    .rf_write_data (rf_write_data),
    .dump_valid    (dump_valid),
    .dump_ready    (dump_ready),
    .dump_index    (dump_index),
    .dump_data     (dump_data),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_data     (load_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected register contents: 0 = preload i*3, 1 = after full load, 2 = after aborted reload
  function automatic logic [31:0] exp_word(input int ds, input int i);
    if (i == 0) return 32'h0;
    if (ds == 0) return 32'(i * 3);
    if (ds == 2 && i < 10) return 32'hB000_0000 + 32'(i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  // mode 0: always ready; 1: ready one cycle in three; 2: always ready plus stray start_dump
  task automatic run_dump(input int mode, input int ds, output int words, output int dones,
                          output int first_valid, output int we_seen);
    logic [31:0] held_d;
    logic [4:0]  held_i;
    logic        stalled;
    words = 0; dones = 0; first_valid = -1; we_seen = 0; stalled = 1'b0;
    held_d = '0; held_i = '0;
    for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
      @(negedge clk);
      dump_ready = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
      if (mode == 2) start_dump = (cyc == 5);
      #1;
      if (rf_we) we_seen++;
      if (done) begin
        dones++;
        check("busy_in_done", 32'(busy), 32'd0);
        if (mode == 2) start_dump = 1'b1;
      end
      if (dump_valid && first_valid < 0) first_valid = cyc;
      if (dump_valid && stalled) begin
        check("hold_index", 32'(dump_index), 32'(held_i));
        check("hold_data", dump_data, held_d);
      end
      if (dump_valid && dump_ready) begin
        check("dump_index", 32'(dump_index), 32'(words));
        check("dump_data", dump_data, exp_word(ds, words));
        words++;
        stalled = 1'b0;
      end else if (dump_valid) begin
        stalled = 1'b1;
        held_d  = dump_data;
        held_i  = dump_index;
      end
    end
    if (dones == 0) check("dump_timeout", 32'd1, 32'd0);
  endtask

  int words, dones, first_valid, we_seen, hs, zero_we;

  initial begin
    reset = 1'b0; preload = 1'b1;
    start_dump = 1'b0; start_load = 1'b0;
    dump_ready = 1'b0; load_valid = 1'b0; load_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_dvalid", 32'(dump_valid), 32'd0);
    check("rst_lready", 32'(load_ready), 32'd0);
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_ddata", dump_data, 32'd0);
    check("rst_dindex", 32'(dump_index), 32'd0);
    @(negedge clk);
    reset = 1'b1; preload = 1'b0;

    // 1: full dump, ready always high
    @(negedge clk); start_dump = 1'b1;
    @(negedge clk); start_dump = 1'b0;
    #1;
    check("t1_busy_c1", 32'(busy), 32'd1);
    check("t1_stall_c1", 32'(cpu_stall), 32'd1);
    check("t1_valid_c1", 32'(dump_valid), 32'd0);
    run_dump(0, 0, words, dones, first_valid, we_seen);
    check("t1_first_valid", 32'(first_valid), 32'd0);
    check("t1_words", 32'(words), 32'd32);
    check("t1_dones", 32'(dones), 32'd1);
    check("t1_we", 32'(we_seen), 32'd0);
    @(negedge clk); #1;
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_done_1cyc", 32'(done), 32'd0);

    // 2: dump with back-pressure
    @(negedge clk); start_dump = 1'b1;
    @(negedge clk); start_dump = 1'b0;
    run_dump(1, 0, words, dones, first_valid, we_seen);
    check("t2_words", 32'(words), 32'd32);
    check("t2_dones", 32'(dones), 32'd1);

    // 3: full load, load_valid gapped one cycle in four
    @(negedge clk); start_load = 1'b1;
    @(negedge clk); start_load = 1'b0;
    hs = 0; zero_we = 0; dones = 0;
    for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      load_valid = (cyc % 4 != 3);
      load_data  = 32'hA000_0000 + 32'(hs);
      #1;
      if (done) dones++;
      if (rf_we && rf_rd_addr == 5'd0) zero_we++;
      if (load_valid && load_ready) begin
        check("t3_rd_addr", 32'(rf_rd_addr), 32'(hs));
        hs++;
      end
    end
    load_valid = 1'b0;
    check("t3_hs", 32'(hs), 32'd32);
    check("t3_dones", 32'(dones), 32'd1);
    check("t3_zero_we", 32'(zero_we), 32'd0);
    for (int i = 0; i < 32; i++) check("t3_rf", rf[i], exp_word(1, i));

    // 4: simultaneous starts, dump must win
    @(negedge clk); start_dump = 1'b1; start_load = 1'b1;
    @(negedge clk); start_dump = 1'b0; start_load = 1'b0;
    #1;
    check("t4_lready", 32'(load_ready), 32'd0);
    run_dump(0, 1, words, dones, first_valid, we_seen);
    check("t4_words", 32'(words), 32'd32);
    check("t4_we", 32'(we_seen), 32'd0);

    // 5: reset asserted while the load sits at index 10
    @(negedge clk); start_load = 1'b1;
    @(negedge clk); start_load = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      load_valid = 1'b1;
      load_data  = 32'hB000_0000 + 32'(i);
      #1;
      if (done) dones++;
      check("t5_rd_addr", 32'(rf_rd_addr), 32'(i));
    end
    @(negedge clk);
    load_valid = 1'b0; reset = 1'b0;
    #1;
    check("t5_at_idx10", 32'(rf_rd_addr), 32'd10);
    @(negedge clk);
    reset = 1'b1;
    #1;
    if (done) dones++;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_lready", 32'(load_ready), 32'd0);
    check("t5_dones", 32'(dones), 32'd0);
    for (int i = 0; i < 32; i++) check("t5_rf", rf[i], exp_word(2, i));

    // 6: stray start_dump mid-operation and in the done cycle
    @(negedge clk); start_dump = 1'b1;
    @(negedge clk); start_dump = 1'b0;
    run_dump(2, 2, words, dones, first_valid, we_seen);
    check("t6_words", 32'(words), 32'd32);
    check("t6_dones", 32'(dones), 32'd1);
    @(negedge clk); start_dump = 1'b0;
    #1;
    check("t6_idle_after", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("t6_still_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
